mem_loader: RTL

Initiator-side sequencer for the nandgame-core memory/register block. It drives that block's x/write port to bulk-load a stream of 16-bit words into consecutive memory addresses.
- Per word: write A with the address, then write M (mem[A]) with the data.
- Used for boot/program load while the CPU core is held off the x/write mux; busy selects the loader.

---
 rtl/mem_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// mem_loader: bulk-loads a stream of 16-bit words into consecutive addresses
// of the nandgame-core memory/register block through its x/write port.
// Each word is written as two steps: load A with the address, then write M
// (mem[A]) with the data. The D register is never touched.
//
// Optional feature macro: MEM_LOADER_VERIFY_EN
//   When defined, every word is read back through a_mem_reg after it is
//   written. The first mismatch sets the sticky error flag, records the
//   address in err_addr and ends the load early.
//   When undefined, a_mem_reg is ignored and error/err_addr stay 0.

module mem_loader #(
  parameter int MEM_SIZE = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] x,
  output logic [2:0]  write,
  input  logic [15:0] a_mem_reg,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_addr
);

  // MEM_SIZE is a power of two, so the wrap is a plain mask.
  localparam logic [15:0] ADDR_MASK = 16'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SET_A     = 3'd1,
    WAIT_DATA = 3'd2,
    WR_M      = 3'd3,
    CHK_WAIT  = 3'd4,
    CHK       = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] addr_r;
  logic [15:0] data_r;
  logic [15:0] cnt_r;
  logic        s_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic [15:0] err_addr_r;
  logic [15:0] x_s;
  logic [2:0]  write_s;

  // Next address, wrapping modulo MEM_SIZE.
  function automatic logic [15:0] addr_inc(input logic [15:0] a);
    return (a + 16'd1) & ADDR_MASK;
  endfunction

  // Previous address, wrapping modulo MEM_SIZE (recovers the address just written).
  function automatic logic [15:0] addr_dec(input logic [15:0] a);
    return (a - 16'd1) & ADDR_MASK;
  endfunction

  // Load sequencer: state, address/count/data registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= 16'h0000;
      data_r     <= 16'h0000;
      cnt_r      <= 16'h0000;
      s_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_addr_r <= 16'h0000;
    end else begin
      // Defaults: pulses drop, busy holds; individual states override.
      s_ready_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r     <= base_addr & ADDR_MASK;
            cnt_r      <= length;
            error_r    <= 1'b0;
            err_addr_r <= 16'h0000;
            if (length == 16'd0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= SET_A;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        SET_A: begin
          state_r   <= WAIT_DATA;
          s_ready_r <= 1'b1;
        end
        WAIT_DATA: begin
          if (s_valid) begin
            data_r  <= s_data;
            state_r <= WR_M;
          end else begin
            // No timeout: the stream may stall indefinitely.
            s_ready_r <= 1'b1;
          end
        end
        WR_M: begin
          addr_r <= addr_inc(addr_r);
          cnt_r  <= cnt_r - 16'd1;
`ifdef MEM_LOADER_VERIFY_EN
          state_r <= CHK_WAIT;
`else
          if (cnt_r == 16'd1) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= SET_A;
          end
`endif
        end
`ifdef MEM_LOADER_VERIFY_EN
        CHK_WAIT: begin
          // a_mem_reg settles to the freshly written mem[A] during this cycle.
          state_r <= CHK;
        end
        CHK: begin
          if (a_mem_reg != data_r) begin
            error_r    <= 1'b1;
            err_addr_r <= addr_dec(addr_r);
            state_r    <= DONE;
            done_r     <= 1'b1;
          end else if (cnt_r == 16'd0) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= SET_A;
          end
        end
`endif
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Memory-port decode; write is forced idle while rst is high so a reset
  // landing mid-load cannot complete a half-finished write.
  always_comb begin
    x_s     = 16'h0000;
    write_s = 3'b000;
    if (rst) begin
      x_s     = 16'h0000;
      write_s = 3'b000;
    end else begin
      case (state_r)
        SET_A: begin
          x_s     = addr_r;
          write_s = 3'b100;
        end
        WR_M: begin
          x_s     = data_r;
          write_s = 3'b001;
        end
        default: begin
          x_s     = 16'h0000;
          write_s = 3'b000;
        end
      endcase
    end
  end

`ifndef MEM_LOADER_VERIFY_EN
  // Read-back port has no consumer without the verify feature.
  logic unused_s;
  assign unused_s = ^a_mem_reg;
`endif

  assign s_ready  = s_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign err_addr = err_addr_r;
  assign x        = x_s;
  assign write    = write_s;

endmodule
